// File: rtl/moduloio_seq_pkg.sv
// Shared definitions for the sequential I/O module: command encoding,
// converter FSM states and the double-dabble digit adjust helper.
package moduloio_pkg;

  localparam logic [1:0] CTRL_NONE  = 2'b00;
  localparam logic [1:0] CTRL_LOAD  = 2'b01;
  localparam logic [1:0] CTRL_PRINT = 2'b10;
  localparam logic [1:0] CTRL_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  // One double-dabble step on a single BCD digit, applied before the shift.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
    return (digit >= BCD_ADJ_THRESH) ? 4'(digit + BCD_ADJ) : digit;
  endfunction

endpackage

// File: rtl/moduloio_seq_if.sv
// Switch/display side bundle of the I/O module; master drives commands,
// slave (the I/O module) returns captured data and BCD digits.
interface moduloio_seq_if #(
  parameter int unsigned W = 16,
  parameter int unsigned D = 5
);

  logic [W-1:0]   entrada;
  logic [1:0]     controle_moduloio;
  logic [W-1:0]   imprimir;
  logic [W-1:0]   dado;
  logic [4*D-1:0] digitos;
  logic           ocupado;
  logic           pronto;
  logic           estouro;
  logic           descartado;

  modport master (
    output entrada, controle_moduloio, imprimir,
    input  dado, digitos, ocupado, pronto, estouro, descartado
  );

  modport slave (
    input  entrada, controle_moduloio, imprimir,
    output dado, digitos, ocupado, pronto, estouro, descartado
  );

endinterface

// File: rtl/moduloio_seq_bcd_seq_conv.sv
// Multi-cycle binary to packed BCD converter (shift-add-3), one bit per clock.
// Results and the overflow flag are held until the next conversion finishes.
module bcd_seq_conv
  import moduloio_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned D = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   value,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] digits,
  output logic           ovf
);

  localparam int unsigned BW = 4 * D;
  localparam int unsigned CW = $clog2(W + 1);

  conv_state_e     state_q, state_d;
  logic [W-1:0]    bin_q;
  logic [BW-1:0]   acc_q;
  logic [BW-1:0]   acc_adj;
  logic            ovf_acc_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   digits_q;
  logic            ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the per-digit adjust feeding the CONV shift.
  always_comb begin
    state_d = state_q;
    acc_adj = '0;
    for (int i = 0; i < int'(D); i++) begin
      acc_adj[4*i +: 4] = bcd_adjust(acc_q[4*i +: 4]);
    end
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q     <= value;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= CW'(W);
            busy_q    <= 1'b1;
          end
        end
        CONV: begin
          // Bit leaving the top digit means the value does not fit in D digits.
          acc_q     <= {acc_adj[BW-2:0], bin_q[W-1]};
          bin_q     <= bin_q << 1;
          ovf_acc_q <= ovf_acc_q | acc_adj[BW-1];
          cnt_q     <= cnt_q - CW'(1);
        end
        DONE: begin
          digits_q <= acc_q;
          ovf_q    <= ovf_acc_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign digits = digits_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/moduloio_seq.sv
// Sequential I/O module: synchronised switch capture into dado and
// binary-to-BCD display path driven by the datapath's I/O commands.
module moduloio_seq
  import moduloio_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned D = 5
) (
  input  logic           clk,
  input  logic           rst,
  moduloio_seq_if.slave  io
);

  logic [W-1:0]   sync1_q;
  logic [W-1:0]   sync2_q;
  logic [W-1:0]   dado_q;
  logic           descartado_q;
  logic           load_c;
  logic           print_c;
  logic           conv_busy;
  logic           conv_done;
  logic [4*D-1:0] conv_digits;
  logic           conv_ovf;

  assign load_c  = |(io.controle_moduloio & CTRL_LOAD);
  assign print_c = |(io.controle_moduloio & CTRL_PRINT);

  // Two-flop synchroniser for the asynchronous switches, then load on command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dado_q  <= '0;
    end else begin
      sync1_q <= io.entrada;
      sync2_q <= sync1_q;
      if (load_c) dado_q <= sync2_q;
    end
  end

  // A print arriving while a conversion runs is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) descartado_q <= 1'b0;
    else     descartado_q <= print_c & conv_busy;
  end

  bcd_seq_conv #(
    .W (W),
    .D (D)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (print_c),
    .value  (io.imprimir),
    .busy   (conv_busy),
    .done   (conv_done),
    .digits (conv_digits),
    .ovf    (conv_ovf)
  );

  assign io.dado       = dado_q;
  assign io.digitos    = conv_digits;
  assign io.ocupado    = conv_busy;
  assign io.pronto     = conv_done;
  assign io.estouro    = conv_ovf;
  assign io.descartado = descartado_q;

endmodule

// File: tb/tb_moduloio_seq.sv
// Scoreboard bench for moduloio_seq: a D=5 and a D=4 instance share clk/rst.
module tb_moduloio_seq;
  import moduloio_pkg::*;

  localparam int unsigned W = 16;

  typedef struct {
    logic [19:0] dig;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pronto5 = 0, desc5 = 0, busy_run5 = 0;
  int   pronto4 = 0, busy_run4 = 0;
  exp_t q5[$];
  exp_t q4[$];

  moduloio_seq_if #(.W(16), .D(5)) b5 ();
  moduloio_seq_if #(.W(16), .D(4)) b4 ();

  moduloio_seq #(.W(16), .D(5)) dut5 (.clk(clk), .rst(rst), .io(b5));
  moduloio_seq #(.W(16), .D(4)) dut4 (.clk(clk), .rst(rst), .io(b4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the D=5 instance: compare every pronto against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy_run5 = 0;
    end else begin
      if (b5.descartado) desc5++;
      if (b5.pronto) begin
        pronto5++;
        if (q5.size() == 0) begin
          check("pronto5_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q5.pop_front();
          check("digitos5", 32'(b5.digitos), 32'(e.dig));
          check("estouro5", 32'(b5.estouro), 32'(e.ovf));
          check("latency5", cyc, e.due);
          check("ocupado_len5", busy_run5, W + 1);
        end
        busy_run5 = 0;
      end else if (b5.ocupado) busy_run5++;
      else busy_run5 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_run4 = 0;
    end else begin
      if (b4.pronto) begin
        pronto4++;
        if (q4.size() == 0) begin
          check("pronto4_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          check("digitos4", 32'(b4.digitos), 32'(e.dig));
          check("estouro4", 32'(b4.estouro), 32'(e.ovf));
          check("latency4", cyc, e.due);
          check("ocupado_len4", busy_run4, W + 1);
        end
        busy_run4 = 0;
      end else if (b4.ocupado) busy_run4++;
      else busy_run4 = 0;
    end
  end

  task automatic print5(input logic [1:0] ctrl, input logic [15:0] v,
                        input logic [19:0] dig, input logic ovf, input bit accept);
    exp_t e;
    @(negedge clk);
    b5.imprimir = v;
    b5.controle_moduloio = ctrl;
    @(posedge clk);
    #1;
    if (accept) begin
      e.dig = dig; e.ovf = ovf; e.due = cyc + W + 1;
      q5.push_back(e);
    end
    @(negedge clk);
    b5.controle_moduloio = CTRL_NONE;
    b5.imprimir = ~v;
  endtask

  task automatic print4(input logic [15:0] v, input logic [19:0] dig, input logic ovf);
    exp_t e;
    @(negedge clk);
    b4.imprimir = v;
    b4.controle_moduloio = CTRL_PRINT;
    @(posedge clk);
    #1;
    e.dig = dig; e.ovf = ovf; e.due = cyc + W + 1;
    q4.push_back(e);
    @(negedge clk);
    b4.controle_moduloio = CTRL_NONE;
    b4.imprimir = ~v;
  endtask

  task automatic drain5();
    for (int i = 0; i < 60 && q5.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("drain5", q5.size(), 0);
    q5.delete();
  endtask

  task automatic drain4();
    for (int i = 0; i < 60 && q4.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check("drain4", q4.size(), 0);
    q4.delete();
  endtask

  initial begin
    int p0, d0;
    b5.entrada = 16'hFFFF; b5.controle_moduloio = CTRL_BOTH; b5.imprimir = 16'd99;
    b4.entrada = '0;       b4.controle_moduloio = CTRL_NONE; b4.imprimir = '0;
    repeat (3) @(negedge clk);
    check("rst_dado", 32'(b5.dado), 32'd0);
    check("rst_digitos", 32'(b5.digitos), 32'd0);
    check("rst_ocupado", 32'(b5.ocupado), 32'd0);
    check("rst_pronto", 32'(b5.pronto), 32'd0);
    check("rst_estouro", 32'(b5.estouro), 32'd0);
    check("rst_descartado", 32'(b5.descartado), 32'd0);
    b5.entrada = '0; b5.controle_moduloio = CTRL_NONE; b5.imprimir = '0;
    rst = 1'b0;

    // 1: basic conversion
    print5(CTRL_PRINT, 16'd12345, 20'h12345, 1'b0, 1'b1);
    drain5();

    // 2: max value then zero, second issued right after pronto
    p0 = pronto5;
    print5(CTRL_PRINT, 16'd65535, 20'h65535, 1'b0, 1'b1);
    drain5();
    print5(CTRL_PRINT, 16'd0, 20'h00000, 1'b0, 1'b1);
    drain5();
    check("pronto_count_t2", pronto5 - p0, 2);

    // 3: D=4 overflow then in-range
    print4(16'd12345, 20'h02345, 1'b1);
    drain4();
    check("estouro4_held", 32'(b4.estouro), 32'd1);
    print4(16'd9999, 20'h09999, 1'b0);
    drain4();

    // 4: print while busy is discarded
    p0 = pronto5; d0 = desc5;
    print5(CTRL_PRINT, 16'd500, 20'h00500, 1'b0, 1'b1);
    @(negedge clk);
    print5(CTRL_PRINT, 16'd777, 20'h0, 1'b0, 1'b0);
    drain5();
    repeat (25) @(negedge clk);
    check("pronto_count_t4", pronto5 - p0, 1);
    check("descartado_count_t4", desc5 - d0, 1);

    // 5: input path, then load+print together
    b5.entrada = 16'hA5A5;
    repeat (2) @(posedge clk);
    #1;
    check("dado_hold", 32'(b5.dado), 32'd0);
    @(negedge clk);
    b5.controle_moduloio = CTRL_LOAD;
    @(posedge clk); #1;
    check("dado_load", 32'(b5.dado), 32'h0000A5A5);
    @(negedge clk);
    b5.controle_moduloio = CTRL_NONE;
    b5.entrada = 16'h0042;
    repeat (2) @(posedge clk);
    #1;
    check("dado_hold2", 32'(b5.dado), 32'h0000A5A5);
    print5(CTRL_BOTH, 16'd42, 20'h00042, 1'b0, 1'b1);
    check("dado_both", 32'(b5.dado), 32'h00000042);
    drain5();

    // 6: reset in the middle of a conversion
    print5(CTRL_PRINT, 16'd999, 20'h0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("ocupado_before_rst", 32'(b5.ocupado), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dado", 32'(b5.dado), 32'd0);
    check("mid_rst_digitos", 32'(b5.digitos), 32'd0);
    check("mid_rst_ocupado", 32'(b5.ocupado), 32'd0);
    check("mid_rst_digitos4", 32'(b4.digitos), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    print5(CTRL_PRINT, 16'd321, 20'h00321, 1'b0, 1'b1);
    drain5();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
